// File: rtl/board_gen_master_pkg.sv
// rtl/board_gen_master_pkg.sv - shared types and helpers for the board generator
package board_gen_master_pkg;

    localparam int MAX_BOARD = 16;

    typedef struct packed {
        logic       mine;
        logic       revealed;
        logic       flagged;
        logic       rsvd;
        logic [3:0] count;
    } field_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLACE,
        ST_COUNT,
        ST_FIN
    } gen_state_t;

    function automatic logic [7:0] cell_adr(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

    function automatic field_t count_field(input logic [3:0] n);
        field_t f;
        f       = '0;
        f.count = n;
        return f;
    endfunction

    function automatic field_t mine_field();
        field_t f;
        f      = '0;
        f.mine = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - classic wishbone link between board generator and board memory
interface wishbone_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [7:0]  adr_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        ack_i;
    logic        stall_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i, stall_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i, stall_i
    );
endinterface

// File: rtl/board_gen_master_lfsr.sv
// rtl/board_gen_master_lfsr.sv - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
module board_lfsr16 #(
    parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VALUE;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/board_gen_master.sv
// rtl/board_gen_master.sv - wishbone initiator that clears, mines and numbers a board
module board_gen_master
    import board_gen_master_pkg::*;
#(
    parameter int          BOARD_SIZE = 16,
    parameter int          MINE_COUNT = 40,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed_i,
    input  logic [3:0]  safe_row,
    input  logic [3:0]  safe_col,
    output logic        busy,
    output logic        done,
    wishbone_if.master  master
);

    localparam logic [4:0] BS    = 5'(BOARD_SIZE > MAX_BOARD ? MAX_BOARD : BOARD_SIZE);
    localparam logic [3:0] LAST  = 4'(BOARD_SIZE - 1);
    localparam logic [8:0] MINES = 9'(MINE_COUNT);

    gen_state_t  state, state_n;
    logic        cyc, cyc_n, gap, gap_n, we, we_n, wr_pend, wr_pend_n;
    logic [7:0]  adr, adr_n;
    field_t      wdat, wdat_n, rd;
    logic [3:0]  row, row_n, col, col_n, srow, srow_n, scol, scol_n;
    logic [3:0]  nb, nb_n, cnt, cnt_n;
    logic [8:0]  mines, mines_n;
    logic        lfsr_load, lfsr_en;
    logic [15:0] lfsr;
    logic [2:0]  k;
    logic [4:0]  dr, dc, nr, nc;
    logic        n_inb, cand_ok, last_cell;
    logic [3:0]  row_adv, col_adv;
    logic        unused_bits;

    board_lfsr16 #(.RESET_VALUE(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  ((seed_i == 16'h0000) ? LFSR_SEED : seed_i),
        .en    (lfsr_en),
        .state (lfsr)
    );

    assign master.cyc_o = cyc;
    assign master.stb_o = cyc;
    assign master.we_o  = we;
    assign master.adr_o = adr;
    assign master.dat_o = {8'h00, wdat};
    assign busy = (state != ST_IDLE) && (state != ST_FIN);
    assign done = (state == ST_FIN);

    assign rd          = field_t'(master.dat_i[7:0]);
    assign unused_bits = ^{master.dat_i[15:8], master.stall_i, lfsr[15:8],
                           rd.revealed, rd.flagged, rd.rsvd, rd.count};

    assign last_cell = (row == LAST) && (col == LAST);
    assign col_adv   = (col == LAST) ? 4'd0 : col + 4'd1;
    assign row_adv   = (col == LAST) ? row + 4'd1 : row;
    assign cand_ok   = ({1'b0, lfsr[7:4]} < BS) && ({1'b0, lfsr[3:0]} < BS) &&
                       !((lfsr[7:4] == srow) && (lfsr[3:0] == scol));

    // Neighbour index nb=1..8 walks NW,N,NE,W,E,SW,S,SE; 5-bit sums expose -1 and BS as out of range.
    always_comb begin
        k  = nb[2:0] - 3'd1;
        dr = (k < 3'd3) ? 5'h1f : ((k < 3'd5) ? 5'h00 : 5'h01);
        if (k == 3'd0 || k == 3'd3 || k == 3'd5) begin
            dc = 5'h1f;
        end else if (k == 3'd1 || k == 3'd6) begin
            dc = 5'h00;
        end else begin
            dc = 5'h01;
        end
        nr    = {1'b0, row} + dr;
        nc    = {1'b0, col} + dc;
        n_inb = (nr < BS) && (nc < BS);
    end

    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        gap_n     = gap;
        we_n      = we;
        adr_n     = adr;
        wdat_n    = wdat;
        wr_pend_n = wr_pend;
        row_n     = row;
        col_n     = col;
        srow_n    = srow;
        scol_n    = scol;
        nb_n      = nb;
        cnt_n     = cnt;
        mines_n   = mines;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    srow_n    = safe_row;
                    scol_n    = safe_col;
                    lfsr_load = 1'b1;
                    row_n     = 4'd0;
                    col_n     = 4'd0;
                    nb_n      = 4'd0;
                    cnt_n     = 4'd0;
                    mines_n   = 9'd0;
                    wr_pend_n = 1'b0;
                    gap_n     = 1'b0;
                    state_n   = ST_CLEAR;
                end
            end
            ST_FIN: state_n = ST_IDLE;
            default: begin
                if (cyc) begin
                    if (master.ack_i) begin
                        cyc_n = 1'b0;
                        gap_n = 1'b1;
                        case (state)
                            ST_CLEAR: begin
                                if (last_cell) begin
                                    state_n = ST_PLACE;
                                end else begin
                                    row_n = row_adv;
                                    col_n = col_adv;
                                end
                            end
                            ST_PLACE: begin
                                if (we) begin
                                    mines_n   = mines + 9'd1;
                                    wr_pend_n = 1'b0;
                                end else if (!rd.mine) begin
                                    wr_pend_n = 1'b1;
                                end
                            end
                            default: begin
                                if (nb == 4'd0 && !rd.mine) begin
                                    nb_n  = 4'd1;
                                    cnt_n = 4'd0;
                                end else if (nb == 4'd0 || nb == 4'd9) begin
                                    nb_n = 4'd0;
                                    if (last_cell) begin
                                        state_n = ST_FIN;
                                    end else begin
                                        row_n = row_adv;
                                        col_n = col_adv;
                                    end
                                end else begin
                                    cnt_n = cnt + {3'b000, rd.mine};
                                    nb_n  = nb + 4'd1;
                                end
                            end
                        endcase
                    end
                end else if (gap) begin
                    gap_n = 1'b0;
                end else begin
                    case (state)
                        ST_CLEAR: begin
                            cyc_n  = 1'b1;
                            we_n   = 1'b1;
                            adr_n  = cell_adr(row, col);
                            wdat_n = '0;
                        end
                        ST_PLACE: begin
                            if (wr_pend) begin
                                cyc_n  = 1'b1;
                                we_n   = 1'b1;
                                wdat_n = mine_field();
                            end else if (mines == MINES) begin
                                state_n = ST_COUNT;
                                row_n   = 4'd0;
                                col_n   = 4'd0;
                                nb_n    = 4'd0;
                            end else begin
                                lfsr_en = 1'b1;
                                if (cand_ok) begin
                                    cyc_n = 1'b1;
                                    we_n  = 1'b0;
                                    adr_n = lfsr[7:0];
                                end
                            end
                        end
                        default: begin
                            if (nb == 4'd0) begin
                                cyc_n = 1'b1;
                                we_n  = 1'b0;
                                adr_n = cell_adr(row, col);
                            end else if (nb == 4'd9) begin
                                cyc_n  = 1'b1;
                                we_n   = 1'b1;
                                adr_n  = cell_adr(row, col);
                                wdat_n = count_field(cnt);
                            end else if (n_inb) begin
                                cyc_n = 1'b1;
                                we_n  = 1'b0;
                                adr_n = cell_adr(nr[3:0], nc[3:0]);
                            end else begin
                                nb_n = nb + 4'd1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cyc     <= 1'b0;
            gap     <= 1'b0;
            we      <= 1'b0;
            adr     <= 8'h00;
            wdat    <= '0;
            wr_pend <= 1'b0;
            row     <= 4'd0;
            col     <= 4'd0;
            srow    <= 4'd0;
            scol    <= 4'd0;
            nb      <= 4'd0;
            cnt     <= 4'd0;
            mines   <= 9'd0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            gap     <= gap_n;
            we      <= we_n;
            adr     <= adr_n;
            wdat    <= wdat_n;
            wr_pend <= wr_pend_n;
            row     <= row_n;
            col     <= col_n;
            srow    <= srow_n;
            scol    <= scol_n;
            nb      <= nb_n;
            cnt     <= cnt_n;
            mines   <= mines_n;
        end
    end

endmodule
